// File: rtl/swd_target.sv
// swd_target: SWD target-side line engine. It oversamples SWDCLK/SWDIO on CLK and hands each decoded request to a DP/AP backend.
// Build option: define SWD_TARGET_WAIT_EN so that a missing backend response answers WAIT instead of FAULT.
module swd_target #(
  parameter int LRST_BITS = 50
) (
  input  logic        CLK,
  input  logic        PORESETn,
  input  logic        SWDCLK,
  input  logic        SWDIN,
  output logic        SWDOUT,
  output logic        SWDOUTEN,
  output logic        REQ_VALID,
  output logic        REQ_APNDP,
  output logic        REQ_RNW,
  output logic [1:0]  REQ_ADDR,
  input  logic        RSP_VALID,
  input  logic [2:0]  RSP_ACK,
  input  logic [31:0] RSP_RDATA,
  output logic        WR_VALID,
  output logic [31:0] WR_DATA,
  output logic        WR_PERR,
  output logic        LINE_RESET,
  output logic        PROTO_ERR
);

  typedef enum logic [3:0] {LOCKOUT, IDLE, REQ, TRN1, ACK, RDATA, TRN_END, TRN2W, WDATA} state_t;

  localparam logic [2:0] ACK_OK = 3'b001;
`ifdef SWD_TARGET_WAIT_EN
  localparam logic [2:0] ACK_NORSP = 3'b010;
`else
  localparam logic [2:0] ACK_NORSP = 3'b100;
`endif
  localparam logic [5:0] LRST_MAX  = 6'(LRST_BITS);
  localparam logic [5:0] LRST_LAST = 6'(LRST_BITS - 1);

  // clk_sync_reg: [0]/[1] synchroniser stages, [2] previous value used for edge detection
  logic [2:0] clk_sync_reg;
  logic [1:0] din_sync_reg;
  logic       rise;
  logic       din;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      clk_sync_reg <= '0;
      din_sync_reg <= '0;
    end else begin
      clk_sync_reg <= {clk_sync_reg[1:0], SWDCLK};
      din_sync_reg <= {din_sync_reg[0], SWDIN};
    end
  end

  assign rise = clk_sync_reg[1] & ~clk_sync_reg[2];
  assign din  = din_sync_reg[1];

  state_t      state_reg, state_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [5:0]  lrst_cnt_reg, lrst_cnt_next;
  logic [5:0]  req_sr_reg, req_sr_next;
  logic [31:0] sh_reg, sh_next;
  logic        par_reg, par_next;
  logic [2:0]  ack_reg, ack_next;
  logic        rsp_seen_reg, rsp_seen_next;
  logic        swdout_reg, swdout_next;
  logic        swdouten_reg, swdouten_next;
  logic        req_valid_reg, req_valid_next;
  logic        req_apndp_reg, req_apndp_next;
  logic        req_rnw_reg, req_rnw_next;
  logic [1:0]  req_addr_reg, req_addr_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic        wr_perr_reg, wr_perr_next;
  logic        line_reset_reg, line_reset_next;
  logic        proto_err_reg, proto_err_next;

  // A response arriving on the very cycle of the latching edge still counts.
  logic [2:0]  rsp_ack_now;
  logic [31:0] rsp_data_now;
  assign rsp_ack_now  = RSP_VALID ? RSP_ACK : (rsp_seen_reg ? ack_reg : ACK_NORSP);
  assign rsp_data_now = RSP_VALID ? RSP_RDATA : sh_reg;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_reg      <= LOCKOUT;
      bit_cnt_reg    <= '0;
      lrst_cnt_reg   <= '0;
      req_sr_reg     <= '0;
      sh_reg         <= '0;
      par_reg        <= 1'b0;
      ack_reg        <= '0;
      rsp_seen_reg   <= 1'b0;
      swdout_reg     <= 1'b0;
      swdouten_reg   <= 1'b0;
      req_valid_reg  <= 1'b0;
      req_apndp_reg  <= 1'b0;
      req_rnw_reg    <= 1'b0;
      req_addr_reg   <= '0;
      wr_valid_reg   <= 1'b0;
      wr_data_reg    <= '0;
      wr_perr_reg    <= 1'b0;
      line_reset_reg <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      lrst_cnt_reg   <= lrst_cnt_next;
      req_sr_reg     <= req_sr_next;
      sh_reg         <= sh_next;
      par_reg        <= par_next;
      ack_reg        <= ack_next;
      rsp_seen_reg   <= rsp_seen_next;
      swdout_reg     <= swdout_next;
      swdouten_reg   <= swdouten_next;
      req_valid_reg  <= req_valid_next;
      req_apndp_reg  <= req_apndp_next;
      req_rnw_reg    <= req_rnw_next;
      req_addr_reg   <= req_addr_next;
      wr_valid_reg   <= wr_valid_next;
      wr_data_reg    <= wr_data_next;
      wr_perr_reg    <= wr_perr_next;
      line_reset_reg <= line_reset_next;
      proto_err_reg  <= proto_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    lrst_cnt_next   = lrst_cnt_reg;
    req_sr_next     = req_sr_reg;
    sh_next         = sh_reg;
    par_next        = par_reg;
    ack_next        = ack_reg;
    rsp_seen_next   = rsp_seen_reg;
    swdout_next     = swdout_reg;
    swdouten_next   = swdouten_reg;
    req_valid_next  = 1'b0;
    req_apndp_next  = req_apndp_reg;
    req_rnw_next    = req_rnw_reg;
    req_addr_next   = req_addr_reg;
    wr_valid_next   = 1'b0;
    wr_data_next    = wr_data_reg;
    wr_perr_next    = 1'b0;
    line_reset_next = 1'b0;
    proto_err_next  = proto_err_reg;

    // Backend window: the whole turnaround bit that follows REQ_VALID.
    if (state_reg == TRN1 && RSP_VALID) begin
      rsp_seen_next = 1'b1;
      ack_next      = RSP_ACK;
      sh_next       = RSP_RDATA;
    end

    if (rise) begin
      if (!din)
        lrst_cnt_next = '0;
      else if (lrst_cnt_reg != LRST_MAX)
        lrst_cnt_next = lrst_cnt_reg + 6'd1;

      if (din && lrst_cnt_reg == LRST_LAST) begin
        line_reset_next = 1'b1;
        proto_err_next  = 1'b0;
        state_next      = IDLE;
        swdouten_next   = 1'b0;
        swdout_next     = 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (din) begin
              state_next   = REQ;
              bit_cnt_next = '0;
            end
          end
          REQ: begin
            if (bit_cnt_reg != 6'd6) begin
              req_sr_next  = {din, req_sr_reg[5:1]};
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end else if (!(^req_sr_reg[4:0]) && !req_sr_reg[5] && din) begin
              req_valid_next = 1'b1;
              req_apndp_next = req_sr_reg[0];
              req_rnw_next   = req_sr_reg[1];
              req_addr_next  = {req_sr_reg[3], req_sr_reg[2]};
              rsp_seen_next  = 1'b0;
              state_next     = TRN1;
            end else begin
              proto_err_next = 1'b1;
              state_next     = LOCKOUT;
            end
          end
          TRN1: begin
            ack_next      = rsp_ack_now;
            sh_next       = rsp_data_now;
            par_next      = ^rsp_data_now;
            swdout_next   = rsp_ack_now[0];
            swdouten_next = 1'b1;
            bit_cnt_next  = 6'd1;
            state_next    = ACK;
          end
          ACK: begin
            if (bit_cnt_reg != 6'd3) begin
              swdout_next  = ack_reg[bit_cnt_reg[1:0]];
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end else if (ack_reg == ACK_OK && req_rnw_reg) begin
              swdout_next  = sh_reg[0];
              sh_next      = {1'b0, sh_reg[31:1]};
              bit_cnt_next = 6'd1;
              state_next   = RDATA;
            end else begin
              swdout_next   = 1'b0;
              swdouten_next = 1'b0;
              state_next    = (ack_reg == ACK_OK) ? TRN2W : TRN_END;
            end
          end
          RDATA: begin
            if (bit_cnt_reg < 6'd32) begin
              swdout_next  = sh_reg[0];
              sh_next      = {1'b0, sh_reg[31:1]};
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end else if (bit_cnt_reg == 6'd32) begin
              swdout_next  = par_reg;
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end else begin
              swdout_next   = 1'b0;
              swdouten_next = 1'b0;
              state_next    = TRN_END;
            end
          end
          TRN_END: begin
            swdout_next   = 1'b0;
            swdouten_next = 1'b0;
            state_next    = IDLE;
          end
          TRN2W: begin
            bit_cnt_next = '0;
            par_next     = 1'b0;
            state_next   = WDATA;
          end
          WDATA: begin
            if (bit_cnt_reg != 6'd32) begin
              sh_next      = {din, sh_reg[31:1]};
              par_next     = par_reg ^ din;
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end else begin
              if (din == par_reg) begin
                wr_valid_next = 1'b1;
                wr_data_next  = sh_reg;
              end else begin
                wr_perr_next = 1'b1;
              end
              state_next = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SWDOUT     = swdout_reg;
  assign SWDOUTEN   = swdouten_reg;
  assign REQ_VALID  = req_valid_reg;
  assign REQ_APNDP  = req_apndp_reg;
  assign REQ_RNW    = req_rnw_reg;
  assign REQ_ADDR   = req_addr_reg;
  assign WR_VALID   = wr_valid_reg;
  assign WR_DATA    = wr_data_reg;
  assign WR_PERR    = wr_perr_reg;
  assign LINE_RESET = line_reset_reg;
  assign PROTO_ERR  = proto_err_reg;

endmodule
